fwd_hazard_unit: RTL and testbench

- Parametrised successor to the pipeline forwarding logic: N source operands against M producer stages, plus load-use hazard detection with a multi-cycle stall sequencer.
- Sits between the ID/EX pipeline register and the ALU operand muxes. Drives operand-mux selects, PC/IF-ID write enables and an ID/EX bubble.
- Forward selects are registered, a one-cycle latency matching the existing pipeline timing. Stall control is combinational on entry and registered while held.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/fwd_hazard_unit_if.sv | 37 +++
 rtl/fwd_prio_match.sv | 27 ++
 rtl/fwd_hazard_unit.sv | 93 +++++++++
 tb/tb_fwd_hazard_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard unit.
package hazard_pkg;

  // Forward-select value that keeps the register-file operand.
  localparam int unsigned FWD_RF = 0;

  typedef enum logic [0:0] {
    StIdle,
    StStall
  } stall_state_e;

  // Select width: one code for the register file plus one per producer stage.
  function automatic int unsigned sel_width(input int unsigned num_stg);
    return $clog2(num_stg + 1);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side signal bundle of the forwarding / hazard unit.
interface fwd_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned SEL_W   = sel_width(NUM_STG)
);

  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [NUM_STG*REG_AW-1:0] stg_rd;
  logic [NUM_STG-1:0]        stg_we;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_vld;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_mem_read;
  logic                      mem_busy;
  logic                      flush;

  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic                      pc_we;
  logic                      ifid_we;
  logic                      idex_bubble;

  modport master (
    output ex_src, stg_rd, stg_we, id_src, id_src_vld, ex_rd, ex_mem_read, mem_busy, flush,
    input  fwd_sel, stall, pc_we, ifid_we, idex_bubble
  );

  modport slave (
    input  ex_src, stg_rd, stg_we, id_src, id_src_vld, ex_rd, ex_mem_read, mem_busy, flush,
    output fwd_sel, stall, pc_we, ifid_we, idex_bubble
  );

endinterface

// File: rtl/fwd_prio_match.sv
// Priority comparator for one source operand: nearest writing stage with a matching,
// nonzero destination wins; otherwise the register file is selected.
module fwd_prio_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned SEL_W   = sel_width(NUM_STG)
) (
  input  logic [REG_AW-1:0]         src_i,
  input  logic [NUM_STG*REG_AW-1:0] stg_rd_i,
  input  logic [NUM_STG-1:0]        stg_we_i,
  output logic [SEL_W-1:0]          sel_o
);

  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    // Scan farthest to nearest so the nearest match is the last assignment.
    for (int s = NUM_STG - 1; s >= 0; s--) begin
      if (stg_we_i[s] && (stg_rd_i[s*REG_AW +: REG_AW] != '0) &&
          (stg_rd_i[s*REG_AW +: REG_AW] == src_i)) begin
        sel_o = SEL_W'(s + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects (registered) plus load-use stall sequencing for the
// ID/EX stage: stall is combinational on entry and held by the FSM afterwards.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned NUM_STG  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SEL_W    = sel_width(NUM_STG)
) (
  input logic              CLK,
  input logic              RESET,
  fwd_hazard_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LOAD_LAT) + 1;

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_d, fwd_sel_q;
  logic                     hz;
  logic                     stall;
  stall_state_e             state_d, state_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_prio_match #(
      .REG_AW  (REG_AW),
      .NUM_STG (NUM_STG),
      .SEL_W   (SEL_W)
    ) u_match (
      .src_i    (bus.ex_src[i*REG_AW +: REG_AW]),
      .stg_rd_i (bus.stg_rd),
      .stg_we_i (bus.stg_we),
      .sel_o    (fwd_sel_d[i*SEL_W +: SEL_W])
    );
  end

  always_comb begin
    hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_vld[i] && (bus.id_src[i*REG_AW +: REG_AW] == bus.ex_rd)) hz = 1'b1;
    end
    hz = hz & bus.ex_mem_read & (bus.ex_rd != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = hz & ~bus.flush;
        if (stall && (LOAD_LAT > 1)) begin
          state_d = StStall;
          cnt_d   = CNT_W'(LOAD_LAT - 2);
        end
      end
      StStall: begin
        stall = 1'b1;
        if (bus.flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (!bus.mem_busy) state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A hazard presented while reset is held must never stall the pipeline.
    if (!RESET) stall = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      fwd_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign bus.fwd_sel     = fwd_sel_q;
  assign bus.stall       = stall;
  assign bus.pc_we       = ~stall;
  assign bus.ifid_we     = ~stall;
  assign bus.idex_bubble = stall | bus.flush;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two units (LOAD_LAT 1 and 3) share one stimulus stream; a monitor
// compares every cycle against a stall-debt / stage-search reference model.
module tb_fwd_hazard_unit;
  import hazard_pkg::*;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned NUM_STG = 2;
  localparam int unsigned SEL_W   = sel_width(NUM_STG);

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  fwd_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .SEL_W(SEL_W))
    bus1 ();
  fwd_hazard_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .SEL_W(SEL_W))
    bus3 ();

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .LOAD_LAT(1), .SEL_W(SEL_W)
  ) u_dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus1)
  );

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .LOAD_LAT(3), .SEL_W(SEL_W)
  ) u_dut3 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus3)
  );

  typedef struct {
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] ex_src;
    logic [NUM_STG*REG_AW-1:0] stg_rd;
    logic [NUM_STG-1:0]        stg_we;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_vld;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_mem_read;
    logic                      mem_busy;
    logic                      flush;
  } stim_t;

  typedef struct {
    logic [NUM_SRC*SEL_W-1:0] fwd;
    logic                     stall1;
    logic                     bubble1;
    logic                     stall3;
    logic                     bubble3;
    string                    tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: fwd value latched at the last edge, and stall cycles still owed.
  logic [NUM_SRC*SEL_W-1:0] fwd_prev = '0;
  int                       owed1    = 0;
  int                       owed3    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s.rst_n = 1'b1;      s.ex_src = '0;     s.stg_rd = '0;       s.stg_we = '0;
    s.id_src = '0;       s.id_src_vld = '0; s.ex_rd = '0;        s.ex_mem_read = 1'b0;
    s.mem_busy = 1'b0;   s.flush = 1'b0;
    return s;
  endfunction

  function automatic logic [NUM_SRC*SEL_W-1:0] model_fwd(input stim_t s);
    logic [NUM_SRC*SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int best;
      int src;
      best = 0;
      src  = int'(s.ex_src[i*REG_AW +: REG_AW]);
      for (int k = 0; k < NUM_STG; k++) begin
        if (best == 0 && s.stg_we[k] && src != 0 && int'(s.stg_rd[k*REG_AW +: REG_AW]) == src)
          best = k + 1;
      end
      r[i*SEL_W +: SEL_W] = SEL_W'(best);
    end
    return r;
  endfunction

  function automatic bit model_hz(input stim_t s);
    bit any;
    any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (s.id_src_vld[i] && s.id_src[i*REG_AW +: REG_AW] == s.ex_rd) any = 1'b1;
    return s.ex_mem_read && (s.ex_rd != 0) && any;
  endfunction

  function automatic int next_owed(input int owed, input int lat, input stim_t s, input bit hz);
    if (!s.rst_n) return 0;
    if (owed > 0) begin
      if (s.flush) return 0;
      if (owed == 1 && s.mem_busy) return 1;
      return owed - 1;
    end
    if (hz && !s.flush) return lat - 1;
    return 0;
  endfunction

  task automatic drive(input stim_t s);
    RESET = s.rst_n;
    bus1.ex_src = s.ex_src;   bus3.ex_src = s.ex_src;
    bus1.stg_rd = s.stg_rd;   bus3.stg_rd = s.stg_rd;
    bus1.stg_we = s.stg_we;   bus3.stg_we = s.stg_we;
    bus1.id_src = s.id_src;   bus3.id_src = s.id_src;
    bus1.id_src_vld = s.id_src_vld;   bus3.id_src_vld = s.id_src_vld;
    bus1.ex_rd = s.ex_rd;     bus3.ex_rd = s.ex_rd;
    bus1.ex_mem_read = s.ex_mem_read; bus3.ex_mem_read = s.ex_mem_read;
    bus1.mem_busy = s.mem_busy;       bus3.mem_busy = s.mem_busy;
    bus1.flush = s.flush;     bus3.flush = s.flush;
  endtask

  // Apply one cycle of stimulus, queue its expected outputs, advance the model.
  task automatic step(input stim_t s, input string tag);
    exp_t e;
    bit   hz;
    @(posedge CLK);
    #1;
    drive(s);
    hz        = model_hz(s);
    e.fwd     = fwd_prev;
    e.stall1  = s.rst_n && (owed1 > 0 || (hz && !s.flush));
    e.stall3  = s.rst_n && (owed3 > 0 || (hz && !s.flush));
    e.bubble1 = e.stall1 | s.flush;
    e.bubble3 = e.stall3 | s.flush;
    e.tag     = tag;
    sb.push_back(e);
    fwd_prev = s.rst_n ? model_fwd(s) : '0;
    owed1    = next_owed(owed1, 1, s, hz);
    owed3    = next_owed(owed3, 3, s, hz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, " fwd_sel L1"}, 32'(bus1.fwd_sel), 32'(e.fwd));
        check({e.tag, " fwd_sel L3"}, 32'(bus3.fwd_sel), 32'(e.fwd));
        check({e.tag, " stall L1"}, 32'(bus1.stall), 32'(e.stall1));
        check({e.tag, " pc_we L1"}, 32'(bus1.pc_we), 32'(!e.stall1));
        check({e.tag, " ifid_we L1"}, 32'(bus1.ifid_we), 32'(!e.stall1));
        check({e.tag, " bubble L1"}, 32'(bus1.idex_bubble), 32'(e.bubble1));
        check({e.tag, " stall L3"}, 32'(bus3.stall), 32'(e.stall3));
        check({e.tag, " pc_we L3"}, 32'(bus3.pc_we), 32'(!e.stall3));
        check({e.tag, " ifid_we L3"}, 32'(bus3.ifid_we), 32'(!e.stall3));
        check({e.tag, " bubble L3"}, 32'(bus3.idex_bubble), 32'(e.bubble3));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    stim_t hzs;
    s = quiet();
    s.rst_n = 1'b0;
    drive(s);

    // Reset, then reset held while a load-use hazard is presented.
    step(s, "reset");
    hzs = quiet();
    hzs.ex_mem_read = 1'b1; hzs.ex_rd = 5'd4; hzs.id_src = {5'd0, 5'd4}; hzs.id_src_vld = 2'b01;
    s = hzs; s.rst_n = 1'b0;
    step(s, "reset_hz");

    // Forwarding: stage0 rd=2 matches rs, rt=3 matches nothing.
    s = quiet(); s.ex_src = {5'd3, 5'd2}; s.stg_rd = {5'd5, 5'd2}; s.stg_we = 2'b11;
    step(s, "fwd_basic");
    s = quiet(); s.ex_src = {5'd0, 5'd7}; s.stg_rd = {5'd7, 5'd7}; s.stg_we = 2'b11;
    step(s, "fwd_nearest");
    s = quiet(); s.ex_src = {5'd5, 5'd0}; s.stg_rd = {5'd5, 5'd0}; s.stg_we = 2'b11;
    step(s, "fwd_r0");
    s = quiet();
    step(s, "idle");

    // Load-use hazard for one cycle, then quiet.
    step(hzs, "ldu");
    for (int i = 0; i < 3; i++) step(quiet(), "ldu_after");
    s = hzs; s.id_src_vld = 2'b00;
    step(s, "ldu_novld");
    step(quiet(), "idle");

    // Memory busy extends the L3 stall by two cycles at the end.
    step(hzs, "busy_c1");
    s = quiet(); s.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step(s, "busy_hold");
    for (int i = 0; i < 2; i++) step(quiet(), "busy_done");

    // Flush on the second stall cycle, then flush together with a hazard.
    step(hzs, "flush_c1");
    s = quiet(); s.flush = 1'b1;
    step(s, "flush_c2");
    step(quiet(), "flush_c3");
    s = hzs; s.flush = 1'b1;
    step(s, "flush_hz");
    step(quiet(), "idle");

    // Reset mid-stall while a forward is active.
    s = hzs; s.ex_src = {5'd0, 5'd2}; s.stg_rd = {5'd0, 5'd2}; s.stg_we = 2'b01;
    step(s, "rst_mid_c1");
    s.rst_n = 1'b0;
    step(s, "rst_mid_c2");
    step(s, "rst_mid_c3");
    step(quiet(), "rst_release");

    // Random traffic over a small register range so matches are frequent.
    for (int n = 0; n < 300; n++) begin
      s.rst_n       = ($urandom_range(0, 39) != 0);
      s.ex_src      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.stg_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.stg_we      = 2'($urandom_range(0, 3));
      s.id_src      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      s.id_src_vld  = 2'($urandom_range(0, 3));
      s.ex_rd       = 5'($urandom_range(0, 7));
      s.ex_mem_read = 1'($urandom_range(0, 1));
      s.mem_busy    = 1'($urandom_range(0, 1));
      s.flush       = ($urandom_range(0, 7) == 0);
      step(s, $sformatf("rand%0d", n));
    end

    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
